// File: rtl/dds_pkg.sv
// dds_pkg: shared types and limits for the quarter-sine DDS sequencer.
package dds_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [1:0] quad_t;
  localparam int ROM_LAT_MAX = 3;
endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase accumulator with a programmable sample-rate divider.
module dds_phase_acc #(
  parameter int PW   = 32,
  parameter int AW   = 8,
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic [PW-1:0]   phase_init,
  input  logic [PW-1:0]   ftw,
  input  logic [DIVW-1:0] div,
  output logic            tick,
  output logic [1:0]      quad,
  output logic [AW-1:0]   idx
);
  logic [PW-1:0]   acc_q, acc_d, ftw_q, ftw_d;
  logic [DIVW-1:0] div_q, div_d, cnt_q, cnt_d;
  always_comb begin
    tick  = en && cnt_q == div_q;
    ftw_d = load ? ftw : ftw_q;
    div_d = load ? div : div_q;
    cnt_d = (load || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    // every tick advances the phase, whether or not the sample gets issued
    acc_d = load ? phase_init : tick ? acc_q + ftw_q : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ftw_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
  assign quad = acc_q[PW-1 -: 2];
  assign idx  = acc_q[PW-3 -: AW];
endmodule

// File: rtl/qsin_dds_ctrl.sv
// qsin_dds_ctrl: sequences quarter-sine ROM reads from a phase accumulator
// and presents quadrant + magnitude on a valid/ready stream.
module qsin_dds_ctrl
  import dds_pkg::*;
#(
  parameter int PW      = 32,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1,
  parameter int DIVW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [PW-1:0]   ftw,
  input  logic [PW-1:0]   phase_init,
  input  logic [DIVW-1:0] rate_div,
  output logic            rom_en,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic [1:0]      out_quadrant,
  output logic [DW-1:0]   out_qsin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            overrun
);
  if (ROM_LAT < 1 || ROM_LAT > ROM_LAT_MAX) begin : g_lat_chk
    $error("ROM_LAT must be within 1..%0d", ROM_LAT_MAX);
  end
  state_t             state_q, state_d;
  logic               rom_en_q, rom_en_d, out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d, idx;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  quad_t              quad_q [ROM_LAT];
  quad_t              quad_d [ROM_LAT];
  quad_t              quad, out_quad_q, out_quad_d;
  logic [DW-1:0]      out_qsin_q, out_qsin_d;
  logic               start_go, tick, in_flight, issue, cap;
  assign start_go  = state_q == IDLE && start && !stop;
  assign in_flight = |vld_q;
  assign issue     = tick && !in_flight && !out_valid_q;
  assign cap       = vld_q[ROM_LAT-1];
  dds_phase_acc #(.PW(PW), .AW(AW), .DIVW(DIVW)) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_go),
    .en         (state_q == RUN),
    .phase_init (phase_init),
    .ftw        (ftw),
    .div        (rate_div),
    .tick       (tick),
    .quad       (quad),
    .idx        (idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // leaving DRAIN looks at next-cycle valid so busy falls right after the last transfer
  always_comb begin
    state_d = (state_q == IDLE && start_go) ? RUN :
              (state_q == RUN && stop) ? DRAIN :
              (state_q == DRAIN && !in_flight && !out_valid_d) ? IDLE : state_q;
  end
  always_comb begin
    rom_en_d    = issue;
    rom_addr_d  = issue ? (quad[0] ? ~idx : idx) : rom_addr_q;
    vld_d[0]    = issue;
    quad_d[0]   = quad;
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      quad_d[i] = quad_q[i-1];
    end
    out_valid_d = cap | (out_valid_q & ~out_ready);
    out_qsin_d  = cap ? rom_data : out_qsin_q;
    out_quad_d  = cap ? quad_q[ROM_LAT-1] : out_quad_q;
    overrun_d   = start_go ? 1'b0 : overrun_q | (tick & ~issue);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      vld_q       <= '0;
      quad_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_qsin_q  <= '0;
      out_quad_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      vld_q       <= vld_d;
      quad_q      <= quad_d;
      out_valid_q <= out_valid_d;
      out_qsin_q  <= out_qsin_d;
      out_quad_q  <= out_quad_d;
      overrun_q   <= overrun_d;
    end
  end
  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign out_valid    = out_valid_q;
  assign out_qsin     = out_qsin_q;
  assign out_quadrant = out_quad_q;
  assign overrun      = overrun_q;
  assign busy         = state_q != IDLE;
endmodule
